// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state constants for ahb_lite_mc_master.

package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StAddr = 2'd1;
   localparam state_t StData = 2'd2;

   function automatic logic [2:0] hsize_for(input int unsigned dw);
      case (dw)
         8:       return HSIZE_BYTE;
         16:      return HSIZE_HALF;
         default: return HSIZE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.

module rr_arbiter #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o
);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      found = 1'b0;
      cand  = '0;
      gnt_o = '0;
      idx_o = '0;
      for (int unsigned off = 0; off < NUM_CH; off++) begin
         cand = IDX_W'((32'(ptr_i) + off) % NUM_CH);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/ahb_lite_mc_master.sv
// Multi-channel AHB-Lite single-transfer master with round-robin arbitration.
// Optional error logging (err_addr/err_cnt) is enabled by defining AHB_ERR_LOG_EN.

module ahb_lite_mc_master
   import ahb_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned AW     = 16,
   parameter int unsigned DW     = 32,
   // One spare select bit so out-of-range channels can be requested and read back as zero.
   parameter int unsigned SEL_W  = $clog2(NUM_CH) + 1
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   input  logic [NUM_CH-1:0]    ch_req,
   input  logic [NUM_CH-1:0]    ch_write,
   input  logic [NUM_CH*AW-1:0] ch_addr,
   input  logic [NUM_CH*DW-1:0] ch_wdata,
   output logic [NUM_CH-1:0]    ch_ack,
   output logic                 ch_err,
   output logic [DW-1:0]        ch_rdata,
   input  logic [SEL_W-1:0]     disp_sel,
   output logic [DW-1:0]        disp_data,
`ifdef AHB_ERR_LOG_EN
   output logic [31:0]          err_addr,
   output logic [15:0]          err_cnt,
`endif
   output logic [31:0]          haddr,
   output logic [1:0]           htrans,
   output logic                 hwrite,
   output logic [2:0]           hsize,
   output logic [2:0]           hburst,
   output logic [DW-1:0]        hwdata,
   input  logic [DW-1:0]        hrdata,
   input  logic                 hready,
   input  logic                 hresp
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  grant_q;
   logic [NUM_CH-1:0] gnt_oh_q;
   logic [IDX_W-1:0]  rr_q;
   logic [AW-1:0]     addr_q;
   logic              write_q;
   logic [DW-1:0]     wdata_q;
   logic [DW-1:0]     last_q [NUM_CH];
   logic [DW-1:0]     disp_q, disp_d;

   logic [NUM_CH-1:0] arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              xfer_done;
   logic              done_ok;
   logic              start;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_rr_arbiter (
      .req_i (ch_req),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign start = (state_q == StIdle) && (|ch_req);

   always_comb begin
      state_d   = state_q;
      xfer_done = 1'b0;
      unique case (state_q)
         StIdle: if (|ch_req) state_d = StAddr;
         StAddr: if (hready) state_d = StData;
         StData: begin
            // An ERROR first cycle arrives with hready=0, so waiting on hready covers it.
            if (hready) begin
               state_d   = StIdle;
               xfer_done = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Completion is suppressed while reset is asserted: the in-flight transfer is dropped.
   assign done_ok = xfer_done && !reset_reset;

   always_comb begin
      disp_d = '0;
      if (32'(disp_sel) < NUM_CH) disp_d = last_q[disp_sel[IDX_W-1:0]];
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         gnt_oh_q <= '0;
         rr_q     <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         disp_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) last_q[i] <= '0;
      end else begin
         state_q <= state_d;
         disp_q  <= disp_d;
         if (start) begin
            grant_q  <= arb_idx;
            gnt_oh_q <= arb_gnt;
            addr_q   <= ch_addr[arb_idx*AW +: AW];
            write_q  <= ch_write[arb_idx];
            wdata_q  <= ch_wdata[arb_idx*DW +: DW];
         end
         if (xfer_done) begin
            rr_q <= (32'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
            if (!hresp && !write_q) last_q[grant_q] <= hrdata;
         end
      end
   end

`ifdef AHB_ERR_LOG_EN
   logic [31:0] err_addr_q;
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         err_addr_q <= '0;
         err_cnt_q  <= '0;
      end else if (xfer_done && hresp) begin
         err_addr_q <= 32'(addr_q);
         if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_addr = err_addr_q;
   assign err_cnt  = err_cnt_q;
`endif

   assign htrans    = (state_q == StAddr) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign haddr     = (state_q == StAddr) ? 32'(addr_q) : 32'd0;
   assign hwrite    = (state_q == StAddr) && write_q;
   assign hsize     = (state_q == StAddr) ? hsize_for(DW) : 3'b000;
   assign hburst    = HBURST_SINGLE;
   assign hwdata    = ((state_q == StData) && write_q) ? wdata_q : '0;
   assign ch_ack    = done_ok ? gnt_oh_q : '0;
   assign ch_err    = done_ok && hresp;
   assign ch_rdata  = (done_ok && !write_q && !hresp) ? hrdata : '0;
   assign disp_data = disp_q;

endmodule

// File: tb/tb_ahb_lite_mc_master.sv
// Scoreboard bench for ahb_lite_mc_master with a scripted AHB slave model.

module tb_ahb_lite_mc_master;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic [3:0]  ch_req, ch_write, ch_ack;
   logic [63:0] ch_addr;
   logic [127:0] ch_wdata;
   logic        ch_err;
   logic [31:0] ch_rdata, disp_data, haddr, hwdata, hrdata;
   logic [2:0]  disp_sel, hsize, hburst;
   logic [1:0]  htrans;
   logic        hwrite, hready, hresp;
`ifdef AHB_ERR_LOG_EN
   logic [31:0] err_addr;
   logic [15:0] err_cnt;
`endif

   ahb_lite_mc_master #(.NUM_CH(4), .AW(16), .DW(32)) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .ch_req      (ch_req),
      .ch_write    (ch_write),
      .ch_addr     (ch_addr),
      .ch_wdata    (ch_wdata),
      .ch_ack      (ch_ack),
      .ch_err      (ch_err),
      .ch_rdata    (ch_rdata),
      .disp_sel    (disp_sel),
      .disp_data   (disp_data),
`ifdef AHB_ERR_LOG_EN
      .err_addr    (err_addr),
      .err_cnt     (err_cnt),
`endif
      .haddr       (haddr),
      .htrans      (htrans),
      .hwrite      (hwrite),
      .hsize       (hsize),
      .hburst      (hburst),
      .hwdata      (hwdata),
      .hrdata      (hrdata),
      .hready      (hready),
      .hresp       (hresp)
   );

   always #5 clk_clk = ~clk_clk;

   typedef struct {
      int          ch;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Slave model script and observations
   int          addr_wait = 0, data_wait = 0;
   bit          err_mode = 0;
   logic [31:0] rdata_val = '0, exp_hwdata = '0;
   int          acnt = 0, dcnt = 0;
   bit          in_data = 0, err_done = 0;
   int          nonseq_cycles = 0, data_cycles = 0, hwdata_hold = 0;
   bit          data_htrans_bad = 0;
   logic [31:0] cap_haddr = '0;
   logic        cap_hwrite = 0;
   logic [2:0]  cap_hsize = '0;

   initial begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      forever begin
         @(negedge clk_clk);
         if (reset_reset) begin
            in_data = 0; acnt = 0; dcnt = 0; err_done = 0;
            hready = 1'b1; hresp = 1'b0;
         end else if (in_data) begin
            data_cycles++;
            if (htrans != 2'b00) data_htrans_bad = 1;
            if (hwdata == exp_hwdata) hwdata_hold++;
            if (dcnt < data_wait) begin
               hready = 1'b0; hresp = 1'b0; dcnt++;
            end else if (err_mode && !err_done) begin
               hready = 1'b0; hresp = 1'b1; err_done = 1;
            end else begin
               hready = 1'b1; hresp = err_mode; hrdata = rdata_val;
               in_data = 0; dcnt = 0; err_done = 0;
            end
         end else if (htrans == 2'b10) begin
            nonseq_cycles++;
            hresp = 1'b0;
            if (acnt < addr_wait) begin
               hready = 1'b0; acnt++;
            end else begin
               hready = 1'b1; cap_haddr = haddr; cap_hwrite = hwrite; cap_hsize = hsize;
               in_data = 1; acnt = 0;
            end
         end else begin
            hready = 1'b1; hresp = 1'b0;
         end
      end
   end

   // Monitor: every ack is matched against the next expected completion
   initial begin
      forever begin
         @(negedge clk_clk);
         #2;
         if (ch_ack != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_ack ch_ack=%b ch_err=%b", ch_ack, ch_err);
            end else begin
               exp_t       e;
               logic [3:0] oh;
               e  = sb.pop_front();
               oh = 4'b0001 << e.ch;
               if (ch_ack !== oh || ch_err !== e.err || ch_rdata !== e.rdata) begin
                  failures++;
                  $display("FAIL ack_ch%0d actual ack=%b err=%b rdata=%h required ack=%b err=%b rdata=%h",
                           e.ch, ch_ack, ch_err, ch_rdata, oh, e.err, e.rdata);
               end
            end
         end
      end
   end

   task automatic clear_obs();
      nonseq_cycles = 0; data_cycles = 0; hwdata_hold = 0; data_htrans_bad = 0;
   endtask

   // Single transfer on one channel; lat counts cycles from the req cycle to the ack cycle
   task automatic do_xfer(input int ch, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                          output int lat);
      exp_t e;
      @(negedge clk_clk);
      clear_obs();
      ch_addr[ch*16 +: 16]  = addr;
      ch_wdata[ch*32 +: 32] = wdata;
      ch_write[ch]          = wr;
      ch_req[ch]            = 1'b1;
      e.ch = ch; e.err = err; e.rdata = rdata;
      sb.push_back(e);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         #2;
         lat++;
         if (ch_ack[ch]) break;
         @(negedge clk_clk);
      end
      ch_req[ch] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_clk);
      reset_reset = 1'b1;
      repeat (2) @(negedge clk_clk);
      reset_reset = 1'b0;
   endtask

   initial begin
      int lat;
      int acks;
      exp_t e;
      reset_reset = 1'b1;
      ch_req = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0; disp_sel = '0;
      repeat (3) @(negedge clk_clk);
      #2;
      chk("rst_htrans", 32'(htrans), 32'h0);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_ack", 32'(ch_ack), 32'h0);
      chk("rst_hwdata", hwdata, 32'h0);
      chk("rst_disp", disp_data, 32'h0);
      chk("hburst", 32'(hburst), 32'h0);
      @(negedge clk_clk);
      reset_reset = 1'b0;

      // 1: ch0 read, zero wait states
      addr_wait = 0; data_wait = 0; err_mode = 0; rdata_val = 32'hDEADBEEF;
      do_xfer(0, 1'b0, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF, lat);
      chk("t1_latency", 32'(lat), 32'd3);
      chk("t1_nonseq_cycles", 32'(nonseq_cycles), 32'd1);
      chk("t1_haddr", cap_haddr, 32'h0000_0010);
      chk("t1_hwrite", 32'(cap_hwrite), 32'h0);
      chk("t1_hsize", 32'(cap_hsize), 32'h2);
      disp_sel = 3'd0;
      repeat (2) @(negedge clk_clk);
      #2;
      chk("t1_disp", disp_data, 32'hDEADBEEF);

      // 2: ch1 write, two data-phase wait states
      data_wait = 2; exp_hwdata = 32'h12345678;
      do_xfer(1, 1'b1, 16'h0020, 32'h12345678, 1'b0, 32'h0, lat);
      chk("t2_latency", 32'(lat), 32'd5);
      chk("t2_hwdata_hold", 32'(hwdata_hold), 32'd3);
      chk("t2_haddr", cap_haddr, 32'h0000_0020);
      chk("t2_hwrite", 32'(cap_hwrite), 32'h1);
      data_wait = 0;

      // 3: all four channels request continuously from reset
      do_reset();
      @(negedge clk_clk);
      ch_write = 4'hF;
      for (int c = 0; c < 4; c++) begin
         ch_addr[c*16 +: 16] = 16'h0100 + 16'(c);
         ch_wdata[c*32 +: 32] = 32'hA000_0000 + 32'(c);
      end
      for (int k = 0; k < 5; k++) begin
         e.ch = k % 4; e.err = 1'b0; e.rdata = 32'h0;
         sb.push_back(e);
      end
      ch_req = 4'hF;
      acks = 0;
      for (int i = 0; i < 100 && acks < 5; i++) begin
         #2;
         if (ch_ack != 0) acks++;
         if (acks == 5) ch_req = 4'h0;
         else @(negedge clk_clk);
      end
      chk("t3_ack_count", 32'(acks), 32'd5);
      repeat (4) @(negedge clk_clk);
      chk("t3_sb_drained", 32'(sb.size()), 32'd0);

      // 4: ch2 read with two-cycle ERROR response
      err_mode = 1; rdata_val = 32'hBAD0BAD0;
      do_xfer(2, 1'b0, 16'h0ABC, 32'h0, 1'b1, 32'h0, lat);
      chk("t4_latency", 32'(lat), 32'd4);
      chk("t4_data_cycles", 32'(data_cycles), 32'd2);
      chk("t4_htrans_idle", 32'(data_htrans_bad), 32'd0);
      err_mode = 0;
      disp_sel = 3'd2;
      repeat (2) @(negedge clk_clk);
      #2;
      chk("t4_last_read_kept", disp_data, 32'h0);
`ifdef AHB_ERR_LOG_EN
      chk("t4_err_cnt", 32'(err_cnt), 32'd1);
      chk("t4_err_addr", err_addr, 32'h0000_0ABC);
`endif

      // 5: reset while address phase is stalled
      addr_wait = 10;
      @(negedge clk_clk);
      ch_addr[3*16 +: 16] = 16'h0300; ch_write[3] = 1'b1; ch_req[3] = 1'b1;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         #2;
         if (htrans == 2'b10) break;
         lat++;
         @(negedge clk_clk);
      end
      chk("t5_reached_addr", 32'(htrans), 32'h2);
      @(negedge clk_clk);
      reset_reset = 1'b1;
      @(negedge clk_clk);
      #2;
      chk("t5_htrans_idle", 32'(htrans), 32'h0);
      chk("t5_no_ack", 32'(ch_ack), 32'h0);
      chk("t5_haddr", haddr, 32'h0);
      @(negedge clk_clk);
      reset_reset = 1'b0; ch_req = '0; addr_wait = 0;
      // rr pointer back at 0: ch1 must win over ch3
      @(negedge clk_clk);
      rdata_val = 32'hCAFEF00D;
      ch_write = 4'b1000; ch_addr[1*16 +: 16] = 16'h0040;
      e.ch = 1; e.err = 1'b0; e.rdata = 32'hCAFEF00D; sb.push_back(e);
      e.ch = 3; e.err = 1'b0; e.rdata = 32'h0;        sb.push_back(e);
      ch_req = 4'b1010;
      for (int i = 0; i < 40 && ch_req != 0; i++) begin
         #2;
         ch_req = ch_req & ~ch_ack;
         @(negedge clk_clk);
      end
      chk("t5_reqs_served", 32'(ch_req), 32'h0);

      // 6: display mux, in range and out of range
      disp_sel = 3'd1;
      repeat (2) @(negedge clk_clk);
      #2;
      chk("t6_disp_ch1", disp_data, 32'hCAFEF00D);
      @(negedge clk_clk);
      disp_sel = 3'd5;
      repeat (2) @(negedge clk_clk);
      #2;
      chk("t6_disp_sel5", disp_data, 32'h0);

      repeat (3) @(negedge clk_clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

endmodule
